// File: rtl/timer_entry_controller.sv
// Keypad-entry sequencer for the microwave timer: debounces raw keys, builds a
// BCD MM:SS entry, validates it on Start and supervises the countdown.
module timer_entry_controller #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter logic [15:0] QUICK_START = 16'h0030
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [9:0]  key_digit,
  input  logic        key_start,
  input  logic        key_cancel,
  input  logic        door_open,
  input  logic        timer_done,
  output logic [15:0] time_bcd,
  output logic        load_pulse,
  output logic        stop_pulse,
  output logic        running,
  output logic        entry_error
);

  typedef enum logic [1:0] {IDLE, ENTRY, RUN} state_t;

  // The sample that first differs leaves the counter at 0, so the Nth stable
  // sample is the one that takes it to N-1; the pulse registers on that edge.
  localparam logic [2:0] FIRE_CNT = 3'(DEBOUNCE - 1);

  function automatic logic onehot12(input logic [11:0] k);
    return (k != 12'd0) && ((k & (k - 12'd1)) == 12'd0);
  endfunction

  function automatic logic [3:0] digit_of(input logic [9:0] d);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++)
      if (d[i]) r = 4'(i);
    return r;
  endfunction

  logic [11:0] key_vec;
  logic [11:0] key_p0;
  logic [2:0]  db_cnt;
  logic [2:0]  db_cnt_next;
  logic        key_vld;
  logic        key_pulse;

  assign key_vec = {key_cancel, key_start, key_digit};
  assign key_vld = onehot12(key_vec);

  always_comb begin
    db_cnt_next = 3'd0;
    if (key_vld && (key_vec == key_p0))
      db_cnt_next = (db_cnt == 3'd7) ? 3'd7 : db_cnt + 3'd1;
  end

  // Stage p0: sampled key, debounce counter and qualified one-shot
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      key_p0    <= 12'd0;
      db_cnt    <= 3'd0;
      key_pulse <= 1'b0;
    end else begin
      key_p0    <= key_vec;
      db_cnt    <= db_cnt_next;
      key_pulse <= key_vld && (db_cnt_next == FIRE_CNT);
    end
  end

  logic sel_digit;
  logic sel_start;
  logic sel_cancel;
  logic [3:0] digit;

  assign sel_digit  = key_pulse && (key_p0[9:0] != 10'd0);
  assign sel_start  = key_pulse && key_p0[10];
  assign sel_cancel = key_pulse && key_p0[11];
  assign digit      = digit_of(key_p0[9:0]);

  state_t     state;
  logic [2:0] digit_count;

  // Stage p1: sequencer acting on the qualified key
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      digit_count <= 3'd0;
      time_bcd    <= 16'h0000;
      load_pulse  <= 1'b0;
      stop_pulse  <= 1'b0;
      running     <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      load_pulse  <= 1'b0;
      stop_pulse  <= 1'b0;
      entry_error <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_digit) begin
            time_bcd    <= {12'h000, digit};
            digit_count <= 3'd1;
            state       <= ENTRY;
          end else if (sel_start && !door_open) begin
            time_bcd   <= QUICK_START;
            load_pulse <= 1'b1;
            running    <= 1'b1;
            state      <= RUN;
          end else if (sel_cancel) begin
            time_bcd <= 16'h0000;
          end
        end
        ENTRY: begin
          if (sel_cancel) begin
            time_bcd    <= 16'h0000;
            digit_count <= 3'd0;
            state       <= IDLE;
          end else if (sel_digit) begin
            if (digit_count < 3'd4) begin
              time_bcd    <= {time_bcd[11:0], digit};
              digit_count <= digit_count + 3'd1;
            end
          end else if (sel_start && !door_open) begin
            // Seconds tens above 5 or an all-zero time cannot be counted down
            if ((time_bcd[7:4] > 4'd5) || (time_bcd == 16'h0000)) begin
              entry_error <= 1'b1;
              time_bcd    <= 16'h0000;
              digit_count <= 3'd0;
              state       <= IDLE;
            end else begin
              load_pulse  <= 1'b1;
              running     <= 1'b1;
              digit_count <= 3'd0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          if (timer_done) begin
            time_bcd <= 16'h0000;
            running  <= 1'b0;
            state    <= IDLE;
          end else if (sel_cancel || door_open) begin
            stop_pulse <= 1'b1;
            time_bcd   <= 16'h0000;
            running    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_entry_controller.sv
// Directed self-checking bench for timer_entry_controller (DEBOUNCE=4).
module tb_timer_entry_controller;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [9:0]  key_digit = 10'd0;
  logic        key_start = 1'b0;
  logic        key_cancel = 1'b0;
  logic        door_open = 1'b0;
  logic        timer_done = 1'b0;
  logic [15:0] time_bcd;
  logic        load_pulse;
  logic        stop_pulse;
  logic        running;
  logic        entry_error;

  int assertions = 0;
  int failures   = 0;

  localparam logic [11:0] START  = 12'h400;
  localparam logic [11:0] CANCEL = 12'h800;

  timer_entry_controller #(.DEBOUNCE(4), .QUICK_START(16'h0030)) dut (
    .clock(clock), .clear(clear), .key_digit(key_digit), .key_start(key_start),
    .key_cancel(key_cancel), .door_open(door_open), .timer_done(timer_done),
    .time_bcd(time_bcd), .load_pulse(load_pulse), .stop_pulse(stop_pulse),
    .running(running), .entry_error(entry_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input logic [11:0] k);
    {key_cancel, key_start, key_digit} = k;
  endtask

  // Hold a key through the debounce window plus the sequencer edge
  task automatic press(input logic [11:0] k);
    set_key(k);
    repeat (5) tick();
  endtask

  task automatic release_key();
    set_key(12'd0);
    tick();
  endtask

  function automatic logic [11:0] dig(input int d);
    logic [11:0] k;
    k = 12'd0;
    k[d] = 1'b1;
    return k;
  endfunction

  initial begin
    int seq1 [5];
    logic [15:0] exp1 [5];
    seq1 = '{1, 2, 3, 0, 9};
    exp1 = '{16'h0001, 16'h0012, 16'h0123, 16'h1230, 16'h1230};

    // Reset
    #2 clear = 1'b0;
    #1;
    chk("rst_time", time_bcd, 16'h0000);
    chk("rst_load", 16'(load_pulse), 16'h0);
    chk("rst_stop", 16'(stop_pulse), 16'h0);
    chk("rst_run", 16'(running), 16'h0);
    chk("rst_err", 16'(entry_error), 16'h0);
    tick();
    tick();
    clear = 1'b1;
    tick();

    // Short press is rejected
    set_key(dig(2));
    repeat (3) tick();
    set_key(12'd0);
    repeat (3) tick();
    chk("db_short", time_bcd, 16'h0000);

    // Long press accepted once
    set_key(dig(2));
    repeat (4) tick();
    chk("db_edge4", time_bcd, 16'h0000);
    tick();
    chk("db_edge5", time_bcd, 16'h0002);
    repeat (5) tick();
    chk("db_hold", time_bcd, 16'h0002);
    release_key();

    press(CANCEL);
    chk("entry_cancel", time_bcd, 16'h0000);
    release_key();

    // Digits shift in; fifth ignored
    for (int i = 0; i < 5; i++) begin
      press(dig(seq1[i]));
      chk($sformatf("shift%0d", i), time_bcd, exp1[i]);
      release_key();
    end
    press(START);
    chk("start_load", 16'(load_pulse), 16'h1);
    chk("start_run", 16'(running), 16'h1);
    chk("start_time", time_bcd, 16'h1230);
    release_key();
    chk("start_load_off", 16'(load_pulse), 16'h0);
    chk("start_run_hold", 16'(running), 16'h1);
    press(dig(5));
    chk("run_digit_ign", time_bcd, 16'h1230);
    release_key();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    chk("done_run", 16'(running), 16'h0);
    chk("done_time", time_bcd, 16'h0000);
    chk("done_stop", 16'(stop_pulse), 16'h0);

    // Invalid seconds tens
    press(dig(1)); release_key();
    press(dig(7)); release_key();
    press(dig(5));
    chk("val_entry", time_bcd, 16'h0175);
    release_key();
    press(START);
    chk("val_err", 16'(entry_error), 16'h1);
    chk("val_time", time_bcd, 16'h0000);
    chk("val_load", 16'(load_pulse), 16'h0);
    chk("val_run", 16'(running), 16'h0);
    release_key();
    chk("val_err_off", 16'(entry_error), 16'h0);

    // All-zero entry rejected
    press(dig(0));
    chk("zero_entry", time_bcd, 16'h0000);
    release_key();
    press(START);
    chk("zero_err", 16'(entry_error), 16'h1);
    chk("zero_load", 16'(load_pulse), 16'h0);
    release_key();

    // Quick start blocked by door, then allowed
    door_open = 1'b1;
    press(START);
    chk("door_time", time_bcd, 16'h0000);
    chk("door_load", 16'(load_pulse), 16'h0);
    chk("door_run", 16'(running), 16'h0);
    release_key();
    door_open = 1'b0;
    press(START);
    chk("qs_time", time_bcd, 16'h0030);
    chk("qs_load", 16'(load_pulse), 16'h1);
    chk("qs_run", 16'(running), 16'h1);
    release_key();
    chk("qs_load_off", 16'(load_pulse), 16'h0);
    door_open = 1'b1;
    tick();
    chk("dopen_stop", 16'(stop_pulse), 16'h1);
    chk("dopen_run", 16'(running), 16'h0);
    chk("dopen_time", time_bcd, 16'h0000);
    tick();
    chk("dopen_stop_off", 16'(stop_pulse), 16'h0);
    door_open = 1'b0;

    // Two keys at once are no key
    set_key(dig(4) | dig(5));
    repeat (10) tick();
    chk("multi_key", time_bcd, 16'h0000);
    release_key();

    // Cancel in RUN aborts
    press(START);
    release_key();
    press(CANCEL);
    chk("cancel_stop", 16'(stop_pulse), 16'h1);
    chk("cancel_run", 16'(running), 16'h0);
    release_key();
    chk("cancel_stop_off", 16'(stop_pulse), 16'h0);

    // timer_done beats a coincident cancel
    press(START);
    release_key();
    chk("coll_run_pre", 16'(running), 16'h1);
    set_key(CANCEL);
    repeat (4) tick();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    chk("coll_run", 16'(running), 16'h0);
    chk("coll_stop", 16'(stop_pulse), 16'h0);
    chk("coll_time", time_bcd, 16'h0000);
    tick();
    chk("coll_stop_late", 16'(stop_pulse), 16'h0);
    release_key();

    // Asynchronous reset in RUN
    press(START);
    release_key();
    chk("ar_run_pre", 16'(running), 16'h1);
    clear = 1'b0;
    #1;
    chk("ar_run", 16'(running), 16'h0);
    chk("ar_time", time_bcd, 16'h0000);
    chk("ar_stop", 16'(stop_pulse), 16'h0);
    tick();
    clear = 1'b1;
    set_key(dig(7));
    repeat (4) tick();
    chk("ar_lat4", time_bcd, 16'h0000);
    tick();
    chk("ar_lat5", time_bcd, 16'h0007);
    release_key();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
